axi4_burst_ram_slave: RTL

- AXI4 slave memory that directly consumes a full-AXI4 master port (AW/W/B/AR/R, no ID/LOCK/CACHE/PROT/QOS signals).
- Serves FIXED and INCR bursts up to 256 beats from an internal word-addressed RAM.
- Write and read channels run concurrently and independently.
- Used as the downstream endpoint for master-side blocks in subsystem and unit benches, and as a small on-chip scratch RAM.

---
 rtl/axi4_burst_ram_slave.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_burst_ram_slave.sv
// -----------------------------------------------------------------------------
// axi4_burst_ram_slave
//   AXI4 slave backed by an internal 32-bit word-addressed RAM. Serves FIXED
//   and INCR bursts of up to 256 beats. The write and read channels run
//   independent FSMs and can be busy at the same time.
//
//   state   | meaning
//   W_IDLE  | AWREADY high, waiting for a write burst address
//   W_DATA  | WREADY high, one beat written per W handshake
//   W_RESP  | BVALID high with OKAY/SLVERR until BREADY
//   R_IDLE  | ARREADY high, waiting for a read burst address
//   R_FETCH | synchronous RAM read of the current beat
//   R_DATA  | RVALID high, RDATA/RRESP/RLAST held until RREADY
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   S_AXI_AW*           write address channel (ADDR, LEN, SIZE, BURST, VALID/READY)
//   S_AXI_W*            write data channel (DATA, STRB, LAST, VALID/READY)
//   S_AXI_B*            write response channel (RESP, VALID/READY)
//   S_AXI_AR*           read address channel (ADDR, LEN, SIZE, BURST, VALID/READY)
//   S_AXI_R*            read data channel (DATA, RESP, LAST, VALID/READY)
// -----------------------------------------------------------------------------
module axi4_burst_ram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR_i,
    input  logic [7:0]        S_AXI_AWLEN_i,
    input  logic [2:0]        S_AXI_AWSIZE_i,
    input  logic [1:0]        S_AXI_AWBURST_i,
    input  logic              S_AXI_AWVALID_i,
    output logic              S_AXI_AWREADY_o,
    input  logic [31:0]       S_AXI_WDATA_i,
    input  logic [3:0]        S_AXI_WSTRB_i,
    input  logic              S_AXI_WLAST_i,
    input  logic              S_AXI_WVALID_i,
    output logic              S_AXI_WREADY_o,
    output logic [1:0]        S_AXI_BRESP_o,
    output logic              S_AXI_BVALID_o,
    input  logic              S_AXI_BREADY_i,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR_i,
    input  logic [7:0]        S_AXI_ARLEN_i,
    input  logic [2:0]        S_AXI_ARSIZE_i,
    input  logic [1:0]        S_AXI_ARBURST_i,
    input  logic              S_AXI_ARVALID_i,
    output logic              S_AXI_ARREADY_o,
    output logic [31:0]       S_AXI_RDATA_o,
    output logic [1:0]        S_AXI_RRESP_o,
    output logic              S_AXI_RLAST_o,
    output logic              S_AXI_RVALID_o,
    input  logic              S_AXI_RREADY_i
);

    localparam int         IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [31:0] r_mem [DEPTH_WORDS];

    // Oversized beats and WRAP/reserved bursts poison the whole burst.
    function automatic logic f_bad_burst(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || burst[1];
    endfunction

    function automatic logic f_out_of_range(input logic [ADDR_W-1:0] addr);
        return {2'b00, addr[ADDR_W-1:2]} >= ADDR_W'(DEPTH_WORDS);
    endfunction

    function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                     input logic [2:0]        size,
                                                     input logic [1:0]        burst);
        if (burst == BURST_INCR)
            return addr + (ADDR_W'(1) << size);
        return addr;
    endfunction

    // ---------------------------------------------------------------- write
    w_state_t          r_w_state;
    logic [ADDR_W-1:0] r_w_addr;
    logic [7:0]        r_w_len;
    logic [7:0]        r_w_cnt;
    logic [2:0]        r_w_size;
    logic [1:0]        r_w_burst;
    logic              r_w_bad;
    logic              r_w_err;
    logic              r_awready;
    logic              r_wready;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    logic w_w_beat;
    logic w_w_final;
    logic w_w_oor;
    logic w_w_beat_err;
    logic w_w_en;

    assign w_w_beat     = S_AXI_WVALID_i && r_wready;
    assign w_w_final    = (r_w_cnt == r_w_len);
    assign w_w_oor      = f_out_of_range(r_w_addr);
    assign w_w_beat_err = w_w_oor || (S_AXI_WLAST_i != w_w_final);
    assign w_w_en       = w_w_beat && !r_w_bad && !w_w_oor && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_state <= W_IDLE;
            r_w_addr  <= '0;
            r_w_len   <= '0;
            r_w_cnt   <= '0;
            r_w_size  <= '0;
            r_w_burst <= '0;
            r_w_bad   <= 1'b0;
            r_w_err   <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_w_state)
                W_IDLE: begin
                    if (S_AXI_AWVALID_i && r_awready) begin
                        r_w_addr  <= S_AXI_AWADDR_i;
                        r_w_len   <= S_AXI_AWLEN_i;
                        r_w_size  <= S_AXI_AWSIZE_i;
                        r_w_burst <= S_AXI_AWBURST_i;
                        r_w_bad   <= f_bad_burst(S_AXI_AWSIZE_i, S_AXI_AWBURST_i);
                        r_w_err   <= f_bad_burst(S_AXI_AWSIZE_i, S_AXI_AWBURST_i);
                        r_w_cnt   <= '0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_beat) begin
                        if (w_w_beat_err)
                            r_w_err <= 1'b1;
                        r_w_addr <= f_next_addr(r_w_addr, r_w_size, r_w_burst);
                        r_w_cnt  <= r_w_cnt + 8'd1;
                        if (w_w_final) begin
                            r_wready  <= 1'b0;
                            r_bvalid  <= 1'b1;
                            r_bresp   <= (r_w_err || w_w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            r_w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY_i) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_w_state <= W_IDLE;
                    end
                end
                default: r_w_state <= W_IDLE;
            endcase
        end
    end

    // RAM contents survive reset, so the array has its own unreset process.
    always_ff @(posedge clk) begin
        if (w_w_en) begin
            for (int b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB_i[b])
                    r_mem[r_w_addr[IDX_W+1:2]][8*b +: 8] <= S_AXI_WDATA_i[8*b +: 8];
            end
        end
    end

    // ----------------------------------------------------------------- read
    r_state_t          r_r_state;
    logic [ADDR_W-1:0] r_r_addr;
    logic [7:0]        r_r_len;
    logic [7:0]        r_r_cnt;
    logic [2:0]        r_r_size;
    logic [1:0]        r_r_burst;
    logic              r_r_bad;
    logic              r_arready;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;

    logic w_r_oor;
    assign w_r_oor = f_out_of_range(r_r_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_state <= R_IDLE;
            r_r_addr  <= '0;
            r_r_len   <= '0;
            r_r_cnt   <= '0;
            r_r_size  <= '0;
            r_r_burst <= '0;
            r_r_bad   <= 1'b0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_rlast   <= 1'b0;
        end else begin
            case (r_r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID_i && r_arready) begin
                        r_r_addr  <= S_AXI_ARADDR_i;
                        r_r_len   <= S_AXI_ARLEN_i;
                        r_r_size  <= S_AXI_ARSIZE_i;
                        r_r_burst <= S_AXI_ARBURST_i;
                        r_r_bad   <= f_bad_burst(S_AXI_ARSIZE_i, S_AXI_ARBURST_i);
                        r_r_cnt   <= '0;
                        r_arready <= 1'b0;
                        r_r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    // Nonblocking RAM write in the same edge means a colliding
                    // write is not seen here; the old word is returned.
                    if (r_r_bad || w_r_oor) begin
                        r_rdata <= '0;
                        r_rresp <= RESP_SLVERR;
                    end else begin
                        r_rdata <= r_mem[r_r_addr[IDX_W+1:2]];
                        r_rresp <= RESP_OKAY;
                    end
                    r_rlast   <= (r_r_cnt == r_r_len);
                    r_rvalid  <= 1'b1;
                    r_r_state <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY_i) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rlast) begin
                            r_arready <= 1'b1;
                            r_r_state <= R_IDLE;
                        end else begin
                            r_r_addr  <= f_next_addr(r_r_addr, r_r_size, r_r_burst);
                            r_r_cnt   <= r_r_cnt + 8'd1;
                            r_r_state <= R_FETCH;
                        end
                    end
                end
                default: r_r_state <= R_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY_o = r_awready;
    assign S_AXI_WREADY_o  = r_wready;
    assign S_AXI_BVALID_o  = r_bvalid;
    assign S_AXI_BRESP_o   = r_bresp;
    assign S_AXI_ARREADY_o = r_arready;
    assign S_AXI_RVALID_o  = r_rvalid;
    assign S_AXI_RDATA_o   = r_rdata;
    assign S_AXI_RRESP_o   = r_rresp;
    assign S_AXI_RLAST_o   = r_rlast;

endmodule
